// File: rtl/mst_pref_pkg.sv
// -----------------------------------------------------------------------------
// mst_pref_pkg
// Shared definitions for the FT600 master-path pre-fetch scheduler and the
// round-robin arbiter it uses. Also imported by the receive-side scheduler.
//   state_t       : scheduler FSM state encoding
//   CHNBIT, NCHN  : channel index width and channel count
//   *_DEF         : default fill length, burst length and counter width
// -----------------------------------------------------------------------------
package mst_pref_pkg;

    localparam int CHNBIT       = 2;
    localparam int NCHN         = 4;
    localparam int FILL_CYC_DEF = 4;
    localparam int BURST_DEF    = 4;
    localparam int CNTBIT_DEF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_FILL   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_XFER   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

endpackage

// File: rtl/mst_rr_arb4.sv
// -----------------------------------------------------------------------------
// mst_rr_arb4
// Purely combinational 4-way round-robin arbiter. Scans req upward starting
// at the channel after rrptr, wrapping around, and grants the first set bit.
// rrptr itself is checked last, so the last winner has lowest priority.
//   req     in  4  request vector
//   rrptr   in  2  index of the most recent grant
//   gnt_vld out 1  at least one request is set
//   gnt_idx out 2  granted channel (rrptr when gnt_vld is 0)
// -----------------------------------------------------------------------------
module mst_rr_arb4
    import mst_pref_pkg::*;
(
    input  logic [NCHN-1:0]   req,
    input  logic [CHNBIT-1:0] rrptr,
    output logic              gnt_vld,
    output logic [CHNBIT-1:0] gnt_idx
);

    logic [CHNBIT-1:0] idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rrptr;
        idx     = '0;
        for (int k = 1; k <= NCHN; k++) begin
            // Two-bit addition wraps naturally across the four channels.
            idx = rrptr + CHNBIT'(k);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mst_pref_sch.sv
// -----------------------------------------------------------------------------
// mst_pref_sch
// Pre-fetch channel scheduler for the FT600 master path. Picks which of the
// four streaming channels owns the pre-fetch buffer (round-robin among
// enabled & requesting channels), runs a fixed-length fill phase (prefena),
// one settle cycle, then a bounded drain burst (prefreq) to the transmitter.
//
// Handshake: txvld (== prefreq) is only raised when txrdy is already high,
// so every cycle with txvld = 1 is a completed word transfer; the buffer
// read is same-cycle with data valid while prefreq is high.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   chnena[3:0]   per-channel enable
//   txreq[3:0]    per-channel transmit request
//   txrdy         transmitter can take a word this cycle
//   prefnempt[3:0] per-channel buffer not-empty
//   prefchn[1:0]  registered channel select to the buffer
//   prefena       registered fill enable
//   prefreq       combinational read strobe
//   txvld         word valid (equals prefreq)
//   txlast        last word of a full-length burst
//   txchn[1:0]    channel of the current word (equals prefchn)
//   busy          FSM not in IDLE
//   dbg_state[2:0] current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module mst_pref_sch
    import mst_pref_pkg::*;
#(
    parameter int FILL_CYC = FILL_CYC_DEF,
    parameter int BURST    = BURST_DEF,
    parameter int CNTBIT   = CNTBIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCHN-1:0]   chnena,
    input  logic [NCHN-1:0]   txreq,
    input  logic              txrdy,
    input  logic [NCHN-1:0]   prefnempt,
    output logic [CHNBIT-1:0] prefchn,
    output logic              prefena,
    output logic              prefreq,
    output logic              txvld,
    output logic              txlast,
    output logic [CHNBIT-1:0] txchn,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam logic [CNTBIT-1:0] FILL_LAST  = CNTBIT'(FILL_CYC - 1);
    localparam logic [CNTBIT-1:0] BURST_LAST = CNTBIT'(BURST - 1);

    state_t            state_q, state_d;
    logic [CHNBIT-1:0] prefchn_q, prefchn_d;
    logic [CHNBIT-1:0] rrptr_q, rrptr_d;
    logic [CNTBIT-1:0] fcnt_q, fcnt_d;
    logic [CNTBIT-1:0] bcnt_q, bcnt_d;
    logic              prefena_q;

    logic [NCHN-1:0]   req;
    logic              gnt_vld;
    logic [CHNBIT-1:0] gnt_idx;
    logic              cur_nempt;
    logic              cur_req;
    logic              rd;

    assign req       = chnena & txreq;
    assign cur_nempt = prefnempt[prefchn_q];
    assign cur_req   = req[prefchn_q];

    mst_rr_arb4 u_arb (
        .req     (req),
        .rrptr   (rrptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        prefchn_d = prefchn_q;
        rrptr_d   = rrptr_q;
        fcnt_d    = fcnt_q;
        bcnt_d    = bcnt_q;
        rd        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                // Request may have vanished between IDLE/GAP and here.
                if (gnt_vld) begin
                    prefchn_d = gnt_idx;
                    rrptr_d   = gnt_idx;
                    fcnt_d    = '0;
                    bcnt_d    = '0;
                    state_d   = ST_FILL;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fcnt_q == FILL_LAST) state_d = ST_SETTLE;
                else                     fcnt_d  = fcnt_q + CNTBIT'(1);
            end
            ST_SETTLE: begin
                // prefchn held one more cycle for the buffer's delayed write.
                state_d = ST_XFER;
            end
            ST_XFER: begin
                rd = txrdy & cur_nempt & cur_req;
                if (rd) begin
                    // Last word leaves the counter at BURST-1; it is cleared at ARB.
                    if (bcnt_q == BURST_LAST) state_d = ST_GAP;
                    else                      bcnt_d  = bcnt_q + CNTBIT'(1);
                end else if (!cur_nempt || !cur_req) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = (|req) ? ST_ARB : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prefchn_q <= '0;
            rrptr_q   <= CHNBIT'(NCHN - 1);
            fcnt_q    <= '0;
            bcnt_q    <= '0;
            prefena_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prefchn_q <= prefchn_d;
            rrptr_q   <= rrptr_d;
            fcnt_q    <= fcnt_d;
            bcnt_q    <= bcnt_d;
            // Registered so prefena is high exactly while the FSM sits in FILL.
            prefena_q <= (state_d == ST_FILL);
        end
    end

    assign prefchn   = prefchn_q;
    assign txchn     = prefchn_q;
    assign prefena   = prefena_q;
    assign prefreq   = rd;
    assign txvld     = rd;
    assign txlast    = rd && (bcnt_q == BURST_LAST);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mst_pref_sch.sv
module tb_mst_pref_sch;
    import mst_pref_pkg::*;

    localparam int FILL  = 4;
    localparam int BURST = 4;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] chnena, txreq, prefnempt;
    logic       txrdy;
    logic [1:0] prefchn, txchn;
    logic       prefena, prefreq, txvld, txlast, busy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    mst_pref_sch dut (
        .clk(clk), .rst(rst), .chnena(chnena), .txreq(txreq), .txrdy(txrdy),
        .prefnempt(prefnempt), .prefchn(prefchn), .prefena(prefena),
        .prefreq(prefreq), .txvld(txvld), .txlast(txlast), .txchn(txchn),
        .busy(busy), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A grant is tracked by its age m_t in cycles since the ARB cycle:
    // 1..FILL fill, FILL+1 settle, >= FILL+2 drain.
    localparam int M_IDLE = 0, M_ARB = 1, M_GRANT = 2, M_GAP = 3;
    int         m_mode;
    int         m_t, m_words;
    int         m_chn, m_ptr;

    function automatic bit m_req(input int c);
        return chnena[c] && txreq[c];
    endfunction

    function automatic bit m_read();
        return (m_mode == M_GRANT) && (m_t >= FILL + 2) && txrdy &&
               prefnempt[m_chn] && m_req(m_chn);
    endfunction

    always @(posedge clk) begin
        int pick;
        bit found;
        if (rst) begin
            m_mode = M_IDLE; m_chn = 0; m_ptr = 3; m_t = 0; m_words = 0;
        end else begin
            case (m_mode)
                M_IDLE: if ((chnena & txreq) != 4'd0) m_mode = M_ARB;
                M_ARB: begin
                    found = 1'b0; pick = 0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && m_req((m_ptr + k) % 4)) begin
                            found = 1'b1; pick = (m_ptr + k) % 4;
                        end
                    end
                    if (found) begin
                        m_chn = pick; m_ptr = pick; m_t = 1; m_words = 0; m_mode = M_GRANT;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
                M_GRANT: begin
                    if (m_t >= FILL + 2) begin
                        if (m_read()) begin
                            m_words++;
                            if (m_words == BURST) m_mode = M_GAP;
                        end else if (!prefnempt[m_chn] || !m_req(m_chn)) begin
                            m_mode = M_GAP;
                        end
                    end
                    m_t++;
                end
                default: m_mode = ((chnena & txreq) != 4'd0) ? M_ARB : M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit     e_rd, e_ena;
        state_t e_st;
        if (cmp_en) begin
            e_rd  = m_read();
            e_ena = (m_mode == M_GRANT) && (m_t >= 1) && (m_t <= FILL);
            case (m_mode)
                M_IDLE:  e_st = ST_IDLE;
                M_ARB:   e_st = ST_ARB;
                M_GAP:   e_st = ST_GAP;
                default: e_st = (m_t <= FILL) ? ST_FILL : (m_t == FILL + 1) ? ST_SETTLE : ST_XFER;
            endcase
            check("prefchn", prefchn, m_chn);
            check("txchn",   txchn,   m_chn);
            check("prefena", prefena, e_ena);
            check("prefreq", prefreq, e_rd);
            check("txvld",   txvld,   e_rd);
            check("txlast",  txlast,  e_rd && (m_words == BURST - 1));
            check("busy",    busy,    m_mode != M_IDLE);
            check("state",   dbg_state, e_st);
        end
    end

    // Grant log: channel captured on the first cycle of each fill phase.
    int got_gnt[$];
    logic ena_prev = 1'b0;
    always @(negedge clk) begin
        if (prefena === 1'b1 && ena_prev !== 1'b1) got_gnt.push_back(int'(prefchn));
        ena_prev = prefena;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk); #1;
    endtask

    task automatic set_in(input logic [3:0] en, input logic [3:0] rq,
                          input logic [3:0] ne, input logic rdy);
        chnena = en; txreq = rq; prefnempt = ne; txrdy = rdy;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_reads(input int n, input int bound, input string name);
        int seen = 0;
        int c = 0;
        while (seen < n && c < bound) begin
            neg(); c++;
            if (prefreq === 1'b1) seen++;
        end
        check(name, seen, n);
    endtask

    task automatic wait_grants(input int n, input int bound, input string name);
        int c = 0;
        while (got_gnt.size() < n && c < bound) begin
            neg(); c++;
        end
        check(name, got_gnt.size(), n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [13:0] t_ena, t_rd, t_last, t_busy;
        int exp_order[4];
        int reads;
        bit seen_last;

        // Reset with all inputs low, held 5 cycles.
        rst = 1'b1;
        set_in(4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        cmp_en = 1'b1;
        repeat (4) step();
        neg();
        check("rst_prefchn", prefchn, 0);
        check("rst_prefena", prefena, 0);
        check("rst_prefreq", prefreq, 0);
        check("rst_txvld",   txvld,   0);
        check("rst_txlast",  txlast,  0);
        check("rst_busy",    busy,    0);
        check("rst_state",   dbg_state, ST_IDLE);
        step(); rst = 1'b0;
        repeat (3) begin neg(); check("idle_busy", busy, 0); end

        // Channel 0 alone: literal cycle timeline from the cycle req rises.
        step();
        set_in(4'h1, 4'h1, 4'h1, 1'b1);
        t_ena  = 14'b10000000111100;
        t_rd   = 14'b00011110000000;
        t_last = 14'b00010000000000;
        t_busy = 14'b11111111111110;
        for (int k = 0; k < 14; k++) begin
            neg();
            check("ch0_prefena", prefena, t_ena[k]);
            check("ch0_prefreq", prefreq, t_rd[k]);
            check("ch0_txlast",  txlast,  t_last[k]);
            check("ch0_busy",    busy,    t_busy[k]);
            if (k == 1 || k == 12) check("ch0_arb",    dbg_state, ST_ARB);
            if (k == 6)            check("ch0_settle", dbg_state, ST_SETTLE);
            if (k == 11)           check("ch0_gap",    dbg_state, ST_GAP);
            if (k == 13)           check("ch0_regrant", prefchn, 0);
        end

        // Channels 0 and 2 alternate.
        step(); set_in(4'h0, 4'h0, 4'h0, 1'b0);
        apply_reset(2);
        got_gnt.delete();
        set_in(4'h5, 4'h5, 4'hF, 1'b1);
        wait_grants(4, 60, "alt_grants");
        exp_order = '{0, 2, 0, 2};
        for (int i = 0; i < 4 && i < got_gnt.size(); i++)
            check("alt_order", got_gnt[i], exp_order[i]);

        // Backpressure on channel 1.
        step(); set_in(4'h0, 4'h0, 4'h0, 1'b0);
        apply_reset(2);
        set_in(4'h2, 4'h2, 4'h2, 1'b1);
        wait_reads(2, 30, "bp_first2");
        step(); txrdy = 1'b0;
        repeat (3) begin
            neg();
            check("bp_hold_req",   prefreq, 0);
            check("bp_hold_state", dbg_state, ST_XFER);
        end
        step(); txrdy = 1'b1;
        neg(); check("bp_w3_req", prefreq, 1); check("bp_w3_last", txlast, 0);
        check("bp_chn", prefchn, 1);
        neg(); check("bp_w4_req", prefreq, 1); check("bp_w4_last", txlast, 1);
        neg(); check("bp_gap", dbg_state, ST_GAP);

        // Short bursts on channel 3: empty, txreq drop, chnena drop.
        for (int v = 0; v < 3; v++) begin
            step(); set_in(4'h0, 4'h0, 4'h0, 1'b0);
            apply_reset(2);
            set_in(4'h8, 4'h8, 4'h8, 1'b1);
            wait_reads(2, 30, "sb_first2");
            step();
            if (v == 0) prefnempt = 4'h0;
            else if (v == 1) txreq = 4'h0;
            else chnena = 4'h0;
            neg();
            check("sb_noread", prefreq, 0);
            check("sb_nolast", txlast, 0);
            check("sb_state",  dbg_state, ST_XFER);
            neg();
            check("sb_gap", dbg_state, ST_GAP);
            step(); set_in(4'h8, 4'h8, 4'h8, 1'b1);
            reads = 0; seen_last = 1'b0;
            for (int c = 0; c < 40 && !seen_last; c++) begin
                neg();
                if (prefreq === 1'b1) reads++;
                if (txlast === 1'b1) seen_last = 1'b1;
            end
            check("sb_next_last", seen_last, 1);
            check("sb_next_reads", reads, 4);
        end

        // Reset mid-FILL (second grant, channel 1), then mid-XFER.
        for (int v = 0; v < 2; v++) begin
            step(); set_in(4'h0, 4'h0, 4'h0, 1'b0);
            apply_reset(2);
            got_gnt.delete();
            set_in(4'hF, 4'hF, 4'hF, 1'b1);
            wait_grants(2, 40, "mr_second");
            if (v == 1) wait_reads(1, 20, "mr_xfer");
            step(); rst = 1'b1;
            neg();
            neg();
            check("mr_state",   dbg_state, ST_IDLE);
            check("mr_prefena", prefena, 0);
            check("mr_prefreq", prefreq, 0);
            check("mr_prefchn", prefchn, 0);
            step(); rst = 1'b0;
            got_gnt.delete();
            wait_grants(1, 20, "mr_regrant");
            if (got_gnt.size() > 0) check("mr_first_chn", got_gnt[0], 0);
        end

        // Randomized traffic against the model.
        step(); set_in(4'h0, 4'h0, 4'h0, 1'b0);
        apply_reset(2);
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 15) == 0) chnena = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  txreq  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)  prefnempt = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            txrdy = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 199) == 0);
        end
        step(); rst = 1'b0;
        neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mst_pref_sch.md
# mst_pref_sch

Pre-fetch channel scheduler for the FT600 master path. It decides which of the four streaming channels owns the pre-fetch buffer at any time, using round-robin order among channels that are enabled and requesting. For the granted channel it runs a fill phase (`prefena`) and then a bounded drain burst (`prefreq`) toward the bus-side transmitter. `prefchn` stays stable for the whole of each grant, including across the buffer's one-cycle write latency.

## Interface
- `FILL_CYC`, 4: cycles `prefena` is held high per grant (1..7).
- `BURST`, 4: maximum words read per grant (1..7).
- `CNTBIT`, 3: width of the fill and burst counters.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `chnena`  in  4  per-channel enable from host configuration.
- `txreq`  in  4  per-channel transmit request from the bus side.
- `txrdy`  in  1  transmitter can accept a word this cycle.
- `prefnempt`  in  4  per-channel not-empty flags from the pre-fetch buffer.
- `prefchn`  out  2  channel select to the pre-fetch buffer (registered).
- `prefena`  out  1  pre-fetch fill enable (registered).
- `prefreq`  out  1  pre-fetch read strobe (combinational).
- `txvld`  out  1  word valid to the transmitter; equal to `prefreq`.
- `txlast`  out  1  last word of a full-length burst.
- `txchn`  out  2  channel of the current word; equal to `prefchn`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `req = chnena & txreq`.
- States:
  - IDLE: leave when `req != 0`; go to ARB.
  - ARB: one cycle. Grant the first set bit of `req` after the round-robin pointer `rrptr`, scanning upward with wrap-around. Register the grant into `prefchn`. Set `rrptr` to the grant. Clear both counters. Go to FILL. If `req` has become 0, return to IDLE with `prefchn` unchanged.
  - FILL: `prefena = 1`. `fcnt` increments each cycle. When `fcnt == FILL_CYC-1`, go to SETTLE.
  - SETTLE: one cycle with `prefena = 0` and `prefchn` held, so the buffer's delayed write lands on the correct channel. Go to XFER.
  - XFER: `prefreq = txrdy & prefnempt[prefchn] & req[prefchn]`. `bcnt` increments on each `prefreq`.
    - `prefreq & bcnt == BURST-1`: go to GAP, with `txlast = 1` on that word.
    - `!prefnempt[prefchn] | !req[prefchn]`: go to GAP with no read and no `txlast` (short burst).
    - `txrdy = 0` with data present: wait in XFER with no read.
  - GAP: one idle cycle. Go to ARB if `req != 0`, otherwise IDLE.
- The scheduler never drives `prefena` and `prefreq` high in the same cycle.
- `txlast = prefreq & (bcnt == BURST-1)`.
- Counters are `CNTBIT` bits wide, unsigned, and never wrap within a grant.

## Timing
- Reset (synchronous): state IDLE, `prefchn = 0`, `prefena = 0`, `rrptr = 3` (channel 0 wins first), counters 0. Combinational outputs follow: `prefreq`, `txvld`, `txlast` and `busy` are all 0.
- Reset asserted in any state returns to IDLE on the next edge. No further `prefreq` is issued after that edge.
- `req` rising while IDLE: ARB on the next cycle, then `prefena` high in the following cycle.
- Fill: `prefena` is high for exactly `FILL_CYC` consecutive cycles per grant.
- Fill to drain: the first possible `prefreq` is `FILL_CYC + 2` cycles after the ARB cycle.
- Drain: one word per cycle when `txrdy` stays high. The read is same-cycle; the buffer data is valid in the cycle `prefreq` is high.
- `prefchn` changes only on the ARB clock edge.
- A single requester is re-granted after GAP (ARB picks it again).
- Two or more requesters alternate strictly, in pointer order.

## Structure
- Shared package `mst_pref_pkg`:
  - state encoding: IDLE, ARB, FILL, SETTLE, XFER, GAP;
  - `CHNBIT = 2`, `NCHN = 4`;
  - default values of `FILL_CYC` and `BURST`.
- Sub-module `mst_rr_arb4`: 4-bit round-robin arbiter. Inputs are `req` and `rrptr`; outputs are `gnt_vld` and `gnt_idx[1:0]`. It is purely combinational and is reused by the receive-side scheduler.

## Test plan
- Reset, with all inputs at 0, held 5 cycles:
  - all outputs 0 and `prefchn = 0`;
  - reset released with `req = 0`: `busy` stays 0.
- Channel 0 only, `prefnempt[0] = 1`, `txrdy = 1`:
  - cycle sequence ARB, FILL ×4 (`prefena = 1`), SETTLE, then `prefreq` ×4;
  - `txlast` on the 4th read, then GAP, then re-grant to channel 0.
- Channels 0 and 2 both requesting:
  - grant order 0, 2, 0, 2;
  - `prefchn` never changes between ARB edges.
- Backpressure during XFER on channel 1:
  - `txrdy` low for 3 cycles after the 2nd word: `prefreq = 0`, state stays XFER;
  - resume: words 3 and 4 follow, `txlast` on word 4.
- Short burst on channel 3:
  - `prefnempt[3]` drops after 2 reads: no `txlast`, GAP next cycle, `bcnt` cleared at the next ARB;
  - the same path is taken when `txreq[3]` or `chnena[3]` drops mid-burst.
- `rst` asserted in mid-FILL and in mid-XFER:
  - next cycle: state IDLE, `prefena = 0`, `prefreq = 0`, `prefchn = 0`;
  - the next grant goes to channel 0.
